// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the PISO serializer:
//                FSM state encoding and the bit-counter width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Serializer FSM states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Bit-counter width: enough to index WIDTH bits, never less than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Load handshake and serial output bundle of the serializer.
//                master : parallel producer / serial consumer side
//                slave  : serializer side
//  Ports       : p_in, load_valid (producer -> serializer)
//                load_ready, s_out, s_valid, s_last, busy (serializer ->)
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] p_in;
  logic             load_valid;
  logic             load_ready;
  logic             s_out;
  logic             s_valid;
  logic             s_last;
  logic             busy;

  modport master (
    output p_in, load_valid,
    input  load_ready, s_out, s_valid, s_last, busy
  );

  modport slave (
    input  p_in, load_valid,
    output load_ready, s_out, s_valid, s_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/piso_serializer_hold_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_hold_buffer
//  Description : One-entry holding register for the next word while the
//                shifter is busy.
//  Ports       : clk_i, reset_i  clock / async active-high reset
//                push_i, data_i  write a word (only when ready_o)
//                pop_i           release the held word
//                data_o, full_o  held word and occupancy flag
//                ready_o         entry free (= !full_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_hold_buffer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             reset_i,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic      [WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  ready_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (push_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o  = data_q;
  assign full_o  = full_q;
  // Depends on the flag only, so there is no path from load_valid.
  assign ready_o = ~full_q;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out serializer with valid/ready load,
//                selectable bit order and a one-word hold buffer so that
//                back-to-back words stream without a gap.
//  Ports       : clk_i, reset_i  clock / async active-high reset
//                bus_if (slave)  p_in, load_valid, load_ready,
//                                s_out, s_valid, s_last, busy
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  wire logic         clk_i,
  input  wire logic         reset_i,
  piso_serializer_if.slave  bus_if
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  piso_state_e       state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [CW-1:0]     cnt_q;
  logic              s_out_q;
  logic              s_valid_q;
  logic              s_last_q;

  logic              w_hold_full;
  logic              w_hold_ready;
  logic [WIDTH-1:0]  w_hold_data;
  logic              w_accept;
  logic              w_last_edge;
  logic              w_push;
  logic              w_pop;
  logic              w_load_direct;
  logic              w_start;
  logic [WIDTH-1:0]  w_start_word;
  logic [CW-1:0]     w_cnt_inc;

  // Bit number idx of the word in transmission order. The shifter is never
  // actually shifted; the counter selects the bit, so fill is irrelevant.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CW-1:0]    idx);
    logic [WIDTH-1:0] shifted;
    if (MSB_FIRST) begin
      shifted = word << idx;
      return shifted[WIDTH-1];
    end else begin
      shifted = word >> idx;
      return shifted[0];
    end
  endfunction

  assign w_accept    = bus_if.load_valid & w_hold_ready;
  assign w_last_edge = (state_q == ST_SHIFT) & s_last_q;
  // Mid-word accepts park in the hold register.
  assign w_push      = w_accept & (state_q == ST_SHIFT) & ~s_last_q;
  // On the last-bit edge a held word has priority; it blocks new accepts anyway.
  assign w_pop       = w_last_edge & w_hold_full;
  assign w_load_direct = w_accept & ((state_q == ST_IDLE) | s_last_q);
  assign w_start     = w_pop | w_load_direct;
  assign w_start_word = w_pop ? w_hold_data : bus_if.p_in;
  assign w_cnt_inc   = cnt_q + CW'(1);

  piso_hold_buffer #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (bus_if.p_in),
    .data_o  (w_hold_data),
    .full_o  (w_hold_full),
    .ready_o (w_hold_ready)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      s_out_q   <= IDLE_LEVEL;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
    end else if (w_start) begin
      // New word: present its first bit on this same edge.
      state_q   <= ST_SHIFT;
      shreg_q   <= w_start_word;
      cnt_q     <= '0;
      s_out_q   <= pick_bit(w_start_word, '0);
      s_valid_q <= 1'b1;
      s_last_q  <= 1'b0;
    end else if ((state_q == ST_SHIFT) && !s_last_q) begin
      cnt_q     <= w_cnt_inc;
      s_out_q   <= pick_bit(shreg_q, w_cnt_inc);
      s_last_q  <= (w_cnt_inc == LAST_IDX);
    end else begin
      state_q   <= ST_IDLE;
      s_out_q   <= IDLE_LEVEL;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
    end
  end

  assign bus_if.load_ready = w_hold_ready;
  assign bus_if.s_out      = s_out_q;
  assign bus_if.s_valid    = s_valid_q;
  assign bus_if.s_last     = s_last_q;
  assign bus_if.busy       = (state_q == ST_SHIFT);

endmodule
`default_nettype wire
